// File: rtl/count_arbiter.sv
// Round-robin arbiter granting a 3-bit T-counter to one of NREQ requesters.
// Ports: clk, rst_n, req, req_len (packed per requester), gnt, t_en, done, busy, steps_left.
module count_arbiter #(
    parameter int NREQ = 4,
    parameter int LW   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*LW-1:0] req_len,
    output logic [NREQ-1:0]    gnt,
    output logic               t_en,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic [LW-1:0]      steps_left
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win_idx;
    logic [NREQ-1:0]  gnt_q;
    logic [LW-1:0]    steps_q;

    logic             found;
    logic [PW-1:0]    pick;
    logic [NREQ-1:0]  pick_oh;
    logic [LW-1:0]    pick_len;
    logic [PW-1:0]    ptr_next;

    // Scan from ptr upward with wrap; first active request wins.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
        pick_oh  = NREQ'(1) << pick;
        pick_len = req_len[pick*LW +: LW];
    end

    assign ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            win_idx <= '0;
            gnt_q   <= '0;
            steps_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state   <= GRANT;
                        gnt_q   <= pick_oh;
                        steps_q <= pick_len;
                        win_idx <= pick;
                    end
                end
                GRANT: begin
                    state <= (steps_q == '0) ? DONE : RUN;
                end
                RUN: begin
                    // Entered only with steps_q >= 1, so this never wraps.
                    steps_q <= steps_q - LW'(1);
                    if (steps_q == LW'(1))
                        state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    gnt_q <= '0;
                    ptr   <= ptr_next;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore outputs: pure decodes of registered state.
    assign gnt        = gnt_q;
    assign t_en       = (state == RUN);
    assign done       = (state == DONE) ? gnt_q : '0;
    assign busy       = (state != IDLE);
    assign steps_left = steps_q;

endmodule
